// File: rtl/pipe_ctrl_if.sv
// Hazard-controller bus: pipeline status in, forwarding selects and stall/flush enables out.
// master drives the pipeline-status side; slave is the controller itself.
interface pipe_ctrl_if #(
  parameter int unsigned STAT_W = 32
);
  logic [4:0]        id_r1_pos;
  logic [4:0]        id_r2_pos;
  logic              id_r1_use;
  logic              id_r2_use;
  logic [4:0]        ex_dst;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_md;
  logic              ex_jb;
  logic [4:0]        mem_dst;
  logic              mem_regwrite;
  logic              halt;
  logic [1:0]        fwd_r1;
  logic [1:0]        fwd_r2;
  logic              lu;
  logic              stall_if;
  logic              stall_id;
  logic              stall_ex;
  logic              flush_id;
  logic              flush_ex;
  logic              md_busy;
  logic              halted;
  logic [STAT_W-1:0] stat_branch;
  logic [STAT_W-1:0] stat_stall;

  modport master (
    output id_r1_pos, id_r2_pos, id_r1_use, id_r2_use, ex_dst, ex_regwrite, ex_memread,
           ex_md, ex_jb, mem_dst, mem_regwrite, halt,
    input  fwd_r1, fwd_r2, lu, stall_if, stall_id, stall_ex, flush_id, flush_ex, md_busy,
           halted, stat_branch, stat_stall
  );

  modport slave (
    input  id_r1_pos, id_r2_pos, id_r1_use, id_r2_use, ex_dst, ex_regwrite, ex_memread,
           ex_md, ex_jb, mem_dst, mem_regwrite, halt,
    output fwd_r1, fwd_r2, lu, stall_if, stall_id, stall_ex, flush_id, flush_ex, md_busy,
           halted, stat_branch, stat_stall
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use, branch flush, multi-cycle EX, halt.
// Optional event counters are built when PIPE_CTRL_STATS_EN is defined.
module pipe_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned STAT_W = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StRun, StMdWait, StHalted} state_e;

  localparam logic [3:0] CntLoad = 4'(MD_LAT - 1);

  state_e     r_state;
  logic [3:0] r_cnt;

  logic       w_luh, w_mdt, w_md_stall, w_branch;
  logic [1:0] w_fwd_r1, w_fwd_r2;
  logic       w_stall_if, w_stall_id, w_stall_ex, w_flush_id, w_flush_ex, w_lu;

  // EX has priority; a load in EX has no result yet, so it never forwards from EX.
  function automatic logic [1:0] fwd_sel(input logic [4:0] pos, input logic use_r,
                                         input logic [4:0] ex_dst, input logic ex_wr,
                                         input logic ex_ld, input logic [4:0] mem_dst,
                                         input logic mem_wr);
    if (!use_r || pos == 5'd0)               return 2'd0;
    else if (ex_wr && !ex_ld && pos == ex_dst) return 2'd1;
    else if (mem_wr && pos == mem_dst)       return 2'd2;
    else                                     return 2'd0;
  endfunction

  assign w_luh = bus.ex_memread && (bus.ex_dst != 5'd0) &&
                 ((bus.id_r1_use && bus.id_r1_pos == bus.ex_dst) ||
                  (bus.id_r2_use && bus.id_r2_pos == bus.ex_dst));
  assign w_mdt      = (r_state == StRun) && bus.ex_md;
  assign w_md_stall = w_mdt || ((r_state == StMdWait) && (r_cnt > 4'd1));

  always_comb begin
    w_fwd_r1   = 2'd0;
    w_fwd_r2   = 2'd0;
    w_stall_if = 1'b0;
    w_stall_id = 1'b0;
    w_stall_ex = 1'b0;
    w_flush_id = 1'b0;
    w_flush_ex = 1'b0;
    w_lu       = 1'b0;
    w_branch   = 1'b0;
    if (!i_rst) begin
      w_fwd_r1 = fwd_sel(bus.id_r1_pos, bus.id_r1_use, bus.ex_dst, bus.ex_regwrite,
                         bus.ex_memread, bus.mem_dst, bus.mem_regwrite);
      w_fwd_r2 = fwd_sel(bus.id_r2_pos, bus.id_r2_use, bus.ex_dst, bus.ex_regwrite,
                         bus.ex_memread, bus.mem_dst, bus.mem_regwrite);
      if (r_state == StHalted || w_md_stall) begin
        w_stall_if = 1'b1;
        w_stall_id = 1'b1;
        w_stall_ex = 1'b1;
      end else if (bus.ex_jb) begin
        w_flush_id = 1'b1;
        w_flush_ex = 1'b1;
        w_branch   = 1'b1;
      end else if (w_luh) begin
        w_stall_if = 1'b1;
        w_stall_id = 1'b1;
        w_flush_ex = 1'b1;
        w_lu       = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StRun;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        StRun: begin
          if (w_mdt) begin
            r_state <= StMdWait;
            r_cnt   <= CntLoad;
          end else if (bus.halt) begin
            r_state <= StHalted;
          end
        end
        StMdWait: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= StRun;
        end
        StHalted: r_state <= StHalted;
        default:  r_state <= StRun;
      endcase
    end
  end

  assign bus.fwd_r1   = w_fwd_r1;
  assign bus.fwd_r2   = w_fwd_r2;
  assign bus.stall_if = w_stall_if;
  assign bus.stall_id = w_stall_id;
  assign bus.stall_ex = w_stall_ex;
  assign bus.flush_id = w_flush_id;
  assign bus.flush_ex = w_flush_ex;
  assign bus.lu       = w_lu;
  assign bus.md_busy  = (r_state == StMdWait);
  assign bus.halted   = (r_state == StHalted);

`ifdef PIPE_CTRL_STATS_EN
  logic [STAT_W-1:0] r_stat_branch, r_stat_stall;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_branch <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_branch && (r_stat_branch != '1)) r_stat_branch <= r_stat_branch + 1'b1;
      if (w_stall_if && (r_state != StHalted) && (r_stat_stall != '1)) begin
        r_stat_stall <= r_stat_stall + 1'b1;
      end
    end
  end

  assign bus.stat_branch = r_stat_branch;
  assign bus.stat_stall  = r_stat_stall;
`else
  logic w_unused_branch;
  assign w_unused_branch = w_branch;
  assign bus.stat_branch = '0;
  assign bus.stat_stall  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MD_LAT=4, STAT_W=4).
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  pipe_ctrl_if #(.STAT_W(4)) bus ();

  pipe_ctrl #(
    .MD_LAT (4),
    .STAT_W (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // {stall_if, stall_id, stall_ex, flush_id, flush_ex, lu}
  logic [5:0] ctl;
  assign ctl = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.flush_id, bus.flush_ex, bus.lu};

`ifdef PIPE_CTRL_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_r1_pos    = 5'd0;
    bus.id_r2_pos    = 5'd0;
    bus.id_r1_use    = 1'b0;
    bus.id_r2_use    = 1'b0;
    bus.ex_dst       = 5'd0;
    bus.ex_regwrite  = 1'b0;
    bus.ex_memread   = 1'b0;
    bus.ex_md        = 1'b0;
    bus.ex_jb        = 1'b0;
    bus.mem_dst      = 5'd0;
    bus.mem_regwrite = 1'b0;
    bus.halt         = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.ex_md = 1'b1; bus.ex_jb = 1'b1; bus.halt = 1'b1;
    bus.id_r1_pos = 5'd5; bus.id_r1_use = 1'b1; bus.ex_dst = 5'd5; bus.ex_regwrite = 1'b1;
    #1;
    n_total++;
    if (ctl !== 6'b000000) $display("FAIL rst_ctl: got %b want %b", ctl, 6'b000000);
    else n_pass++;
    n_total++;
    if (bus.fwd_r1 !== 2'd0) $display("FAIL rst_fwd: got %0d want 0", bus.fwd_r1);
    else n_pass++;
    step();
    step();
    n_total++;
    if (bus.md_busy !== 1'b0 || bus.halted !== 1'b0)
      $display("FAIL rst_state: got busy=%b halted=%b want 0 0", bus.md_busy, bus.halted);
    else n_pass++;
    idle();
    rst = 1'b0;
    #1;
    n_total++;
    if (ctl !== 6'b000000) $display("FAIL rst_idle_ctl: got %b want %b", ctl, 6'b000000);
    else n_pass++;
    n_total++;
    if (bus.stat_branch !== 4'd0 || bus.stat_stall !== 4'd0)
      $display("FAIL rst_stats: got %0d %0d want 0 0", bus.stat_branch, bus.stat_stall);
    else n_pass++;
  endtask

  task automatic test_forwarding();
    idle();
    bus.id_r1_pos = 5'd8; bus.id_r1_use = 1'b1;
    bus.ex_dst = 5'd8; bus.ex_regwrite = 1'b1;
    bus.mem_dst = 5'd8; bus.mem_regwrite = 1'b1;
    #1;
    n_total++;
    if (bus.fwd_r1 !== 2'd1) $display("FAIL fwd_ex_prio: got %0d want 1", bus.fwd_r1);
    else n_pass++;
    bus.ex_regwrite = 1'b0;
    #1;
    n_total++;
    if (bus.fwd_r1 !== 2'd2) $display("FAIL fwd_mem: got %0d want 2", bus.fwd_r1);
    else n_pass++;
    bus.id_r1_pos = 5'd0; bus.ex_dst = 5'd0; bus.mem_dst = 5'd0; bus.ex_regwrite = 1'b1;
    #1;
    n_total++;
    if (bus.fwd_r1 !== 2'd0) $display("FAIL fwd_r0: got %0d want 0", bus.fwd_r1);
    else n_pass++;
    idle();
    bus.id_r2_pos = 5'd12; bus.id_r2_use = 1'b1;
    bus.ex_dst = 5'd12; bus.ex_regwrite = 1'b1; bus.ex_memread = 1'b1;
    bus.mem_dst = 5'd12; bus.mem_regwrite = 1'b1;
    #1;
    n_total++;
    if (bus.fwd_r2 !== 2'd2) $display("FAIL fwd_load_skip: got %0d want 2", bus.fwd_r2);
    else n_pass++;
    bus.id_r2_use = 1'b0;
    #1;
    n_total++;
    if (bus.fwd_r2 !== 2'd0) $display("FAIL fwd_unused: got %0d want 0", bus.fwd_r2);
    else n_pass++;
    idle();
    step();
  endtask

  task automatic test_load_use();
    idle();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_dst = 5'd9;
    bus.id_r2_pos = 5'd9; bus.id_r2_use = 1'b1;
    #1;
    n_total++;
    if (ctl !== 6'b110011) $display("FAIL luh_ctl: got %b want %b", ctl, 6'b110011);
    else n_pass++;
    bus.ex_jb = 1'b1;
    #1;
    n_total++;
    if (ctl !== 6'b000110) $display("FAIL luh_branch: got %b want %b", ctl, 6'b000110);
    else n_pass++;
    step();
    idle();
    #1;
    n_total++;
    if (ctl !== 6'b000000) $display("FAIL luh_bubble: got %b want %b", ctl, 6'b000000);
    else n_pass++;
    bus.ex_memread = 1'b1; bus.ex_dst = 5'd0; bus.id_r1_pos = 5'd0; bus.id_r1_use = 1'b1;
    #1;
    n_total++;
    if (ctl !== 6'b000000) $display("FAIL luh_r0: got %b want %b", ctl, 6'b000000);
    else n_pass++;
    idle();
    step();
  endtask

  task automatic test_multicycle();
    idle();
    bus.ex_md = 1'b1;
    #1;
    n_total++;
    if (ctl !== 6'b111000 || bus.md_busy !== 1'b0)
      $display("FAIL md_c0: got ctl=%b busy=%b want 111000 0", ctl, bus.md_busy);
    else n_pass++;
    step();
    bus.ex_md = 1'b0; bus.ex_jb = 1'b1; bus.halt = 1'b1;
    #1;
    n_total++;
    if (ctl !== 6'b111000 || bus.md_busy !== 1'b1)
      $display("FAIL md_c1: got ctl=%b busy=%b want 111000 1", ctl, bus.md_busy);
    else n_pass++;
    step();
    bus.ex_jb = 1'b0;
    #1;
    n_total++;
    if (ctl !== 6'b111000 || bus.md_busy !== 1'b1)
      $display("FAIL md_c2: got ctl=%b busy=%b want 111000 1", ctl, bus.md_busy);
    else n_pass++;
    step();
    bus.halt = 1'b0;
    #1;
    n_total++;
    if (ctl !== 6'b000000 || bus.md_busy !== 1'b1)
      $display("FAIL md_c3: got ctl=%b busy=%b want 000000 1", ctl, bus.md_busy);
    else n_pass++;
    step();
    n_total++;
    if (ctl !== 6'b000000 || bus.md_busy !== 1'b0 || bus.halted !== 1'b0)
      $display("FAIL md_c4: got ctl=%b busy=%b halted=%b want 000000 0 0",
               ctl, bus.md_busy, bus.halted);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_busy;
    logic [4:0] exp_stall;
    exp_busy  = 5'b01110;
    exp_stall = 5'b10111;
    idle();
    bus.ex_md = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_total++;
      if (bus.stall_ex !== exp_stall[c] || bus.md_busy !== exp_busy[c])
        $display("FAIL b2b_c%0d: got stall=%b busy=%b want %b %b",
                 c, bus.stall_ex, bus.md_busy, exp_stall[c], exp_busy[c]);
      else n_pass++;
      step();
    end
    idle();
    for (int c = 0; c < 3; c++) step();
    n_total++;
    if (bus.md_busy !== 1'b0) $display("FAIL b2b_drain: got busy=%b want 0", bus.md_busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_md();
    idle();
    bus.ex_md = 1'b1;
    #1;
    step();
    bus.ex_md = 1'b0;
    step();
    rst = 1'b1;
    #1;
    n_total++;
    if (ctl !== 6'b000000) $display("FAIL rmd_forced: got %b want %b", ctl, 6'b000000);
    else n_pass++;
    step();
    rst = 1'b0;
    #1;
    n_total++;
    if (ctl !== 6'b000000 || bus.md_busy !== 1'b0)
      $display("FAIL rmd_after: got ctl=%b busy=%b want 000000 0", ctl, bus.md_busy);
    else n_pass++;
  endtask

  task automatic test_halt();
    int n_bad;
    idle();
    bus.halt = 1'b1;
    #1;
    n_total++;
    if (ctl !== 6'b000000 || bus.halted !== 1'b0)
      $display("FAIL halt_req: got ctl=%b halted=%b want 000000 0", ctl, bus.halted);
    else n_pass++;
    step();
    bus.halt = 1'b0;
    #1;
    n_total++;
    if (ctl !== 6'b111000 || bus.halted !== 1'b1)
      $display("FAIL halt_enter: got ctl=%b halted=%b want 111000 1", ctl, bus.halted);
    else n_pass++;
    n_bad = 0;
    for (int i = 0; i < 100; i++) begin
      bus.ex_jb      = i[0];
      bus.ex_memread = i[1];
      bus.ex_dst     = 5'd3;
      bus.id_r1_pos  = 5'd3;
      bus.id_r1_use  = 1'b1;
      bus.ex_md      = i[2];
      #1;
      if (ctl !== 6'b111000 || bus.halted !== 1'b1) n_bad++;
      step();
    end
    n_total++;
    if (n_bad !== 0) $display("FAIL halt_hold: got %0d bad cycles want 0", n_bad);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (ctl !== 6'b000000) $display("FAIL halt_rst_forced: got %b want %b", ctl, 6'b000000);
    else n_pass++;
    step();
    rst = 1'b0;
    idle();
    #1;
    n_total++;
    if (ctl !== 6'b000000 || bus.halted !== 1'b0 || bus.md_busy !== 1'b0)
      $display("FAIL halt_exit: got ctl=%b halted=%b busy=%b want 000000 0 0",
               ctl, bus.halted, bus.md_busy);
    else n_pass++;
  endtask

  task automatic test_stats();
    logic [3:0] exp;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.ex_jb = 1'b1;
    for (int i = 0; i < 5; i++) step();
    exp = StatsOn ? 4'd5 : 4'd0;
    n_total++;
    if (bus.stat_branch !== exp) $display("FAIL stat_br5: got %0d want %0d", bus.stat_branch, exp);
    else n_pass++;
    for (int i = 0; i < 15; i++) step();
    exp = StatsOn ? 4'd15 : 4'd0;
    n_total++;
    if (bus.stat_branch !== exp) $display("FAIL stat_br_sat: got %0d want %0d", bus.stat_branch, exp);
    else n_pass++;
    n_total++;
    if (bus.stat_stall !== 4'd0) $display("FAIL stat_st0: got %0d want 0", bus.stat_stall);
    else n_pass++;
    idle();
    bus.ex_memread = 1'b1; bus.ex_dst = 5'd7; bus.id_r1_pos = 5'd7; bus.id_r1_use = 1'b1;
    for (int i = 0; i < 3; i++) step();
    exp = StatsOn ? 4'd3 : 4'd0;
    n_total++;
    if (bus.stat_stall !== exp) $display("FAIL stat_st3: got %0d want %0d", bus.stat_stall, exp);
    else n_pass++;
    idle();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle();
    test_back_to_back();
    test_reset_mid_md();
    test_halt();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller for the five-stage MIPS core. It sequences the EX stage and its neighbours:
- operand-forwarding selects for the instruction leaving ID;
- load-use bubbles, which also drive the EX-stage `lu` input;
- wrong-path flushes on taken jumps/branches (EX `JB`);
- multi-cycle EX occupancy for mul/div-class ALU ops;
- a sticky halt.

It sits beside the pipeline registers and drives their stall/flush enables.

## Interface
- `MD_LAT`, 4, cycles a multi-cycle op occupies EX; legal range 2..15.
- `STAT_W`, 32, width of statistics counters.

- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_r1_pos`, `id_r2_pos`  in  5 each  source register numbers of the instruction in ID.
- `id_r1_use`, `id_r2_use`  in  1 each  ID instruction reads rs / rt.
- `ex_dst`  in  5  destination register of the EX instruction.
- `ex_regwrite`  in  1  EX instruction writes `ex_dst`.
- `ex_memread`  in  1  EX instruction is a load.
- `ex_md`  in  1  EX instruction is a multi-cycle ALU op.
- `ex_jb`  in  1  EX resolved a taken jump/branch (EX `JB`).
- `mem_dst`  in  5  destination register of the MEM instruction.
- `mem_regwrite`  in  1  MEM instruction writes `mem_dst`.
- `halt`  in  1  halt request from EX (syscall exit).
- `fwd_r1`, `fwd_r2`  out  2 each  operand source: 0 regfile, 1 EX result, 2 MEM result.
- `lu`  out  1  load-use hazard this cycle.
- `stall_if`, `stall_id`, `stall_ex`  out  1 each  hold the PC / IF-ID / ID-EX registers.
- `flush_id`, `flush_ex`  out  1 each  load a bubble into IF-ID / ID-EX.
- `md_busy`  out  1  FSM in MD_WAIT.
- `halted`  out  1  FSM in HALTED.
- `stat_branch`, `stat_stall`  out  `STAT_W` each  event counters.

## Operation
- **FSM states:** RUN, MD_WAIT, HALTED. There is a 4-bit down-counter `cnt`.
- **Forwarding** (combinational, per operand):
  - Operands that are unused, or that read r0, select 0.
  - Select 1 if `ex_regwrite` & !`ex_memread` & pos==`ex_dst`.
  - Else select 2 if `mem_regwrite` & pos==`mem_dst`.
  - Else select 0. EX has priority over MEM.
- **Load-use (LUH):** `ex_memread` & `ex_dst`!=0 & ((r1_use & r1_pos==ex_dst) | (r2_use & r2_pos==ex_dst)).
- **Multi-cycle trigger (MDT):** RUN & `ex_md`.
- **Priority, highest first:**
  1. **HALTED:** `stall_if`, `stall_id` and `stall_ex` are all 1; the flushes and `lu` are 0.
  2. **MD stall** (MDT, or MD_WAIT with `cnt`>1):
     - `stall_if`, `stall_id` and `stall_ex` are all 1.
     - `ex_jb`, LUH and `halt` are ignored.
  3. **Branch:** `ex_jb` → `flush_id`=1 and `flush_ex`=1. LUH is suppressed, because ID holds a wrong-path instruction.
  4. **LUH:** `stall_if`=1, `stall_id`=1, `flush_ex`=1, `lu`=1.
  5. Otherwise all controls are 0.
- **Transitions:**
  - RUN → HALTED when `halt` is high and no MD stall is active.
  - RUN → MD_WAIT on MDT; `cnt` loads `MD_LAT`-1.
  - In MD_WAIT, `cnt` decrements each cycle.
  - MD_WAIT → RUN in the cycle `cnt`==1. That cycle has no stall, so the pipeline advances and the op leaves EX.
  - HALTED is left only via `rst`.
- A new `ex_md` seen in RUN right after MD_WAIT is a new instruction and retriggers MDT.

## Timing
- Forwarding, stall, flush and `lu` are combinational from the inputs and the registered state. None are registered outputs.
- A multi-cycle op holds EX for exactly `MD_LAT` cycles, with stalls asserted for `MD_LAT`-1 of them. Example: `MD_LAT`=4 gives stall in cycles 0, 1, 2 and none in cycle 3.
- LUH costs one bubble cycle. A branch costs two flushed slots in one cycle.
- **While `rst`=1:**
  - all stall/flush/`lu`/`fwd` outputs are forced to 0;
  - at the clock edge, state ← RUN, `cnt` ← 0 and the counters ← 0.
- Reset asserted mid-MD_WAIT or in HALTED aborts to RUN at the next edge.
- Reset values: all outputs 0, including `md_busy`, `halted` and the stats.

## Configuration
- `PIPE_CTRL_STATS_EN` defined:
  - `stat_branch` increments on each cycle where rule 3 fires.
  - `stat_stall` increments on each cycle where `stall_if`=1 and state is not HALTED.
  - Both saturate at all-ones and never wrap.
- Undefined: no counter registers are built; `stat_branch` and `stat_stall` are tied to 0.

## Test plan
- **Forwarding:** `id_r1_pos`=8, `id_r1_use`=1, `ex_dst`=8 with `ex_regwrite`=1, and `mem_dst`=8 with `mem_regwrite`=1 → `fwd_r1`=1. Same with `ex_regwrite`=0 → 2. `id_r1_pos`=0 → 0.
- **Load-use:** `ex_memread`=1, `ex_dst`=9, `id_r2_pos`=9, `id_r2_use`=1 → one cycle of `stall_if`=`stall_id`=`flush_ex`=`lu`=1. Adding `ex_jb`=1 → only `flush_id`=`flush_ex`=1, `lu`=0.
- **Multi-cycle:** `MD_LAT`=4 with a one-cycle `ex_md` pulse → stalls for exactly 3 cycles, `md_busy` high for cycles 1–3, RUN in cycle 4. `ex_jb` pulsed in cycle 1 → no flush.
- **Halt:**
  - `halt`=1 in RUN → `halted`=1 next cycle, all stalls held for 100 cycles.
  - `rst`=1 for one cycle → all outputs 0, RUN.
  - `halt` during an MD stall → ignored.
- **Reset mid-MD:** assert `rst` in MD_WAIT with `cnt`=2 → at the next edge `md_busy`=0, no stall, `cnt`=0.
- **Stats (`PIPE_CTRL_STATS_EN`, `STAT_W`=4):** 20 branch cycles → `stat_branch`=15, saturated. Without the macro → outputs stay 0.
